// File: rtl/ifetch_stage_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and fetch-queue entry layout.
package ifetch_stage_pkg;

  typedef enum logic [1:0] {
    IF_FETCH  = 2'd0,
    IF_DRAIN  = 2'd1,
    IF_FLUSHI = 2'd2
  } ifetch_state;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        acc_err;
  } fetch_entry;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction bus between the fetch stage (master) and the I-cache (slave).
interface ifetch_stage_if;
  logic [63:0] addr;
  logic        en;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic        fence_i;
  logic        acc_err;

  modport master (
    output addr, en, ready, fence_i,
    input  rdata, valid, acc_err
  );

  modport slave (
    input  addr, en, ready, fence_i,
    output rdata, valid, acc_err
  );
endinterface

// File: rtl/ifetch_stage_fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; head is presented combinationally.
module ifetch_stage_fetch_queue
  import ifetch_stage_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_entry wr_data,
  output fetch_entry rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  fetch_entry    mem [QDEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(QDEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: owns the PC, drives the I-cache bus, queues fetched words for decode.
// Optional IFETCH_ACC_FAULT_EN: access faults are forwarded to decode and halt fetch until a redirect.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ifetch_stage_if.master       ibus,
  input  logic                 redirect_en,
  input  logic [63:0]          redirect_pc,
  input  logic                 fence_i_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_pc,
  output logic [31:0]          out_inst,
  output logic                 out_acc_err
);

  ifetch_state state;
  logic [63:0] pc, redir_pc, tgt_pc;
  logic        redir_fence, run, halted, fault;
  logic        q_full, q_empty, hs, push, pop, fetch_en;
  fetch_entry  push_entry, head;

  assign tgt_pc   = align_pc(redirect_pc);
  assign fetch_en = run && (state == IF_FETCH) && !q_full && !halted;

  // A request only rises with a free queue slot, so ready can simply follow en.
  assign ibus.en      = fetch_en || (state == IF_DRAIN);
  assign ibus.ready   = ibus.en;
  assign ibus.addr    = pc;
  assign ibus.fence_i = (state == IF_FLUSHI);

  assign hs   = ibus.en && ibus.valid;
  assign push = hs && (state == IF_FETCH) && !redirect_en;
  assign pop  = out_valid && out_ready && !redirect_en;

`ifdef IFETCH_ACC_FAULT_EN
  assign fault = ibus.acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        halted <= 1'b0;
    else if (redirect_en)           halted <= 1'b0;
    else if (push && ibus.acc_err)  halted <= 1'b1;
  end
`else
  logic unused_acc_err;
  assign unused_acc_err = ibus.acc_err;
  assign fault          = 1'b0;
  assign halted         = 1'b0;
`endif

  assign push_entry.pc      = pc;
  assign push_entry.inst    = fault ? 32'h0 : ibus.rdata;
  assign push_entry.acc_err = fault;

  ifetch_stage_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_en),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign out_valid   = !q_empty;
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_acc_err = out_valid && head.acc_err;

  // run holds the bus idle for the first cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IF_FETCH;
      pc    <= RESET_PC;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      unique case (state)
        IF_FETCH: begin
          if (redirect_en) begin
            if (ibus.en && !hs) begin
              state <= IF_DRAIN;
            end else begin
              pc    <= tgt_pc;
              state <= fence_i_en ? IF_FLUSHI : IF_FETCH;
            end
          end else if (push) begin
            pc <= pc + 64'd4;
          end
        end
        IF_DRAIN: begin
          if (hs) begin
            pc    <= redirect_en ? tgt_pc : redir_pc;
            state <= (redirect_en ? fence_i_en : redir_fence) ? IF_FLUSHI : IF_FETCH;
          end
        end
        IF_FLUSHI: begin
          if (redirect_en) pc <= tgt_pc;
          state <= IF_FETCH;
        end
        default: state <= IF_FETCH;
      endcase
    end
  end

  // Redirect target parked while an in-flight request drains; later redirects overwrite it.
  always_ff @(posedge clk) begin
    if (redirect_en && ((state == IF_FETCH && ibus.en && !hs) || state == IF_DRAIN)) begin
      redir_pc    <= tgt_pc;
      redir_fence <= fence_i_en;
    end
  end

endmodule
